// File: rtl/regfile_wb_if.sv
// Write-back bus bundle for regfile_wb: ALU/accelerator result inputs,
// scoreboard lookups and the registered register-file write port.
interface regfile_wb_if #(
    parameter int ACC_DEPTH = 4
);
    localparam int CW = $clog2(ACC_DEPTH) + 1;

    logic          alu_valid;
    logic          alu_ready;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_wd;
    logic          acc_valid;
    logic          acc_ready;
    logic [4:0]    acc_rd;
    logic [31:0]   acc_wd;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          w_en;
    logic [4:0]    rd;
    logic [31:0]   wd;
    logic [CW-1:0] fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_wd,
        output acc_valid, acc_rd, acc_wd,
        output issue_valid, issue_rd, rs1, rs2,
        input  alu_ready, acc_ready, rs1_busy, rs2_busy,
        input  w_en, rd, wd, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_wd,
        input  acc_valid, acc_rd, acc_wd,
        input  issue_valid, issue_rd, rs1, rs2,
        output alu_ready, acc_ready, rs1_busy, rs2_busy,
        output w_en, rd, wd, fifo_count
    );
endinterface

// File: rtl/regfile_wb.sv
// Register-file write-back arbiter: ALU vs accelerator FIFO plus busy scoreboard.
// Define WB_FAIR_EN to stop the ALU from starving the FIFO indefinitely.
module regfile_wb #(
    parameter int ACC_DEPTH = 4
) (
    input logic         clk,
    input logic         rst_n,
    regfile_wb_if.slave bus
);
    localparam int PW = $clog2(ACC_DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    r_mem_rd [ACC_DEPTH];
    logic [31:0]   r_mem_wd [ACC_DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_busy;
    logic          r_wen;
    logic [4:0]    r_rd;
    logic [31:0]   r_wd;

    logic          w_alu_fire;
    logic          w_push;
    logic          w_pop;
    logic          w_nempty;
    logic [4:0]    w_head_rd;
    logic [31:0]   w_head_wd;
    logic [31:0]   w_set;
    logic [31:0]   w_clr;

    assign w_nempty   = (r_cnt != '0);
    assign w_head_rd  = r_mem_rd[r_rp];
    assign w_head_wd  = r_mem_wd[r_rp];

    // Full blocks pushes outright; a same-cycle pop does not free a slot early.
    assign bus.acc_ready = (r_cnt < CW'(ACC_DEPTH));
    assign w_push        = bus.acc_valid && bus.acc_ready;
    assign w_alu_fire    = bus.alu_valid && bus.alu_ready;
    assign w_pop         = !w_alu_fire && w_nempty;

`ifdef WB_FAIR_EN
    logic [1:0] r_starve;
    logic       w_force;

    assign w_force       = (r_starve == 2'd3);
    assign bus.alu_ready = !w_force;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_pop && w_force) begin
            r_starve <= '0;
        end else if (w_alu_fire && w_nempty) begin
            r_starve <= r_starve + 2'd1;
        end
    end
`else
    assign bus.alu_ready = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wp] <= bus.acc_rd;
            r_mem_wd[r_wp] <= bus.acc_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
        end
    end

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (bus.issue_valid && bus.issue_rd != 5'd0) w_set[bus.issue_rd] = 1'b1;
        if (w_pop) w_clr[w_head_rd] = 1'b1;
    end

    // Set is applied after clear so a re-issue beats the retiring write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'h1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen <= 1'b0;
            r_rd  <= '0;
            r_wd  <= '0;
        end else if (w_alu_fire) begin
            r_wen <= (bus.alu_rd != 5'd0);
            r_rd  <= bus.alu_rd;
            r_wd  <= bus.alu_wd;
        end else if (w_pop) begin
            r_wen <= (w_head_rd != 5'd0);
            r_rd  <= w_head_rd;
            r_wd  <= w_head_wd;
        end else begin
            r_wen <= 1'b0;
        end
    end

    assign bus.rs1_busy   = (bus.rs1 != 5'd0) && r_busy[bus.rs1];
    assign bus.rs2_busy   = (bus.rs2 != 5'd0) && r_busy[bus.rs2];
    assign bus.w_en       = r_wen;
    assign bus.rd         = r_rd;
    assign bus.wd         = r_wd;
    assign bus.fifo_count = r_cnt;
endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: ALU path, accelerator FIFO, scoreboard,
// full/drain ordering (or fairness with WB_FAIR_EN) and mid-run reset.
module tb_regfile_wb;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    regfile_wb_if #(.ACC_DEPTH(4)) bus ();

    regfile_wb #(.ACC_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_check(input string tag, input logic en,
                            input logic [4:0] r, input logic [31:0] d);
        check({tag, ".w_en"}, 32'(bus.w_en), 32'(en));
        check({tag, ".rd"}, 32'(bus.rd), 32'(r));
        check({tag, ".wd"}, bus.wd, d);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_wd      = '0;
        bus.acc_valid   = 1'b0;
        bus.acc_rd      = '0;
        bus.acc_wd      = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rs1         = '0;
        bus.rs2         = '0;

        // reset state
        tick();
        tick();
        wr_check("rst", 1'b0, 5'd0, 32'h0);
        check("rst.count", 32'(bus.fifo_count), 32'd0);
        check("rst.acc_ready", 32'(bus.acc_ready), 32'd1);
        check("rst.alu_ready", 32'(bus.alu_ready), 32'd1);
        rst_n = 1'b1;
        tick();
        check("idle.w_en", 32'(bus.w_en), 32'd0);

        // ALU write visible one cycle later only
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_wd    = 32'hDEADBEEF;
        tick();
        bus.alu_valid = 1'b0;
        wr_check("alu", 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        wr_check("alu.hold", 1'b0, 5'd5, 32'hDEADBEEF);

        // issue then accelerator result
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        bus.rs1         = 5'd7;
        bus.rs2         = 5'd0;
        tick();
        bus.issue_valid = 1'b0;
        check("iss.rs1_busy", 32'(bus.rs1_busy), 32'd1);
        check("iss.rs2_busy", 32'(bus.rs2_busy), 32'd0);
        bus.acc_valid = 1'b1;
        bus.acc_rd    = 5'd7;
        bus.acc_wd    = 32'h12;
        tick();
        bus.acc_valid = 1'b0;
        check("acc.count", 32'(bus.fifo_count), 32'd1);
        check("acc.rs1_busy", 32'(bus.rs1_busy), 32'd1);
        check("acc.pre_w_en", 32'(bus.w_en), 32'd0);
        tick();
        wr_check("acc.pop", 1'b1, 5'd7, 32'h12);
        check("acc.rs1_clr", 32'(bus.rs1_busy), 32'd0);
        check("acc.count0", 32'(bus.fifo_count), 32'd0);

        // set wins over same-cycle clear
        bus.acc_valid = 1'b1;
        bus.acc_rd    = 5'd9;
        bus.acc_wd    = 32'h99;
        tick();
        bus.acc_valid   = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        bus.rs1         = 5'd9;
        tick();
        bus.issue_valid = 1'b0;
        wr_check("setwin", 1'b1, 5'd9, 32'h99);
        check("setwin.busy9", 32'(bus.rs1_busy), 32'd1);

        // ALU write to x0 is swallowed
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_wd    = 32'h1234;
        tick();
        bus.alu_valid = 1'b0;
        check("x0.w_en", 32'(bus.w_en), 32'd0);

`ifdef WB_FAIR_EN
        // one FIFO entry against a permanently valid ALU
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_wd    = 32'hA0;
        bus.acc_valid = 1'b1;
        bus.acc_rd    = 5'd10;
        bus.acc_wd    = 32'h100;
        tick();
        bus.acc_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("fair.alu_ready", 32'(bus.alu_ready), 32'd1);
            tick();
            wr_check("fair.alu", 1'b1, 5'd3, 32'hA0);
        end
        check("fair.alu_block", 32'(bus.alu_ready), 32'd0);
        tick();
        wr_check("fair.pop", 1'b1, 5'd10, 32'h100);
        check("fair.count", 32'(bus.fifo_count), 32'd0);
        check("fair.alu_back", 32'(bus.alu_ready), 32'd1);
        bus.alu_valid = 1'b0;
        tick();
`else
        // fill with ALU hogging, refuse when full, then drain in order
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_wd    = 32'hA0;
        bus.acc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.acc_rd = 5'(10 + i);
            bus.acc_wd = 32'(256 + i);
            tick();
            wr_check("fill.alu", 1'b1, 5'd3, 32'hA0);
        end
        check("full.count", 32'(bus.fifo_count), 32'd4);
        check("full.acc_ready", 32'(bus.acc_ready), 32'd0);
        bus.acc_rd = 5'd20;
        bus.acc_wd = 32'h999;
        tick();
        check("full.refuse", 32'(bus.fifo_count), 32'd4);
        bus.acc_valid = 1'b0;
        bus.alu_valid = 1'b0;
        tick();
        wr_check("drain0", 1'b1, 5'd10, 32'h100);
        check("drain0.count", 32'(bus.fifo_count), 32'd3);
        check("drain0.ready", 32'(bus.acc_ready), 32'd1);
        bus.acc_valid = 1'b1;
        bus.acc_rd    = 5'd14;
        bus.acc_wd    = 32'h104;
        tick();
        bus.acc_valid = 1'b0;
        wr_check("drain1", 1'b1, 5'd11, 32'h101);
        check("pushpop.count", 32'(bus.fifo_count), 32'd3);
        tick();
        wr_check("drain2", 1'b1, 5'd12, 32'h102);
        tick();
        wr_check("drain3", 1'b1, 5'd13, 32'h103);
        tick();
        wr_check("drain4", 1'b1, 5'd14, 32'h104);
        check("drain.count", 32'(bus.fifo_count), 32'd0);
        tick();
        check("drain.idle", 32'(bus.w_en), 32'd0);
`endif

        // reset mid-operation discards queue and scoreboard
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        tick();
        bus.issue_valid = 1'b0;
        bus.alu_valid   = 1'b1;
        bus.alu_rd      = 5'd1;
        bus.alu_wd      = 32'h55;
        bus.acc_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.acc_rd = 5'(16 + i);
            bus.acc_wd = 32'(512 + i);
            tick();
        end
        bus.alu_valid = 1'b0;
        bus.acc_valid = 1'b0;
        bus.rs1       = 5'd7;
        check("prerst.count", 32'(bus.fifo_count), 32'd3);
        check("prerst.busy7", 32'(bus.rs1_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("inrst.count", 32'(bus.fifo_count), 32'd0);
        check("inrst.busy7", 32'(bus.rs1_busy), 32'd0);
        check("inrst.w_en", 32'(bus.w_en), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("postrst.w_en", 32'(bus.w_en), 32'd0);
        check("postrst.count", 32'(bus.fifo_count), 32'd0);
        check("postrst.ready", 32'(bus.acc_ready), 32'd1);
        check("postrst.busy7", 32'(bus.rs1_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
